// File: rtl/br_resolver_pkg.sv
// Shared types and helpers for the branch resolver: FSM state encoding,
// outcome constants and a saturating increment used by the statistics counters.
package br_resolver_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    DLY     = 3'd3,
    RESOLVE = 3'd4
  } state_t;

  localparam logic TAKEN     = 1'b1;
  localparam logic NOT_TAKEN = 1'b0;

  // Width-generic saturating +1: callers zero-extend into 64 bits and truncate back.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Handshake bundle between the branch source, the resolver and the 2-bit predictor.
// slave: the resolver side; master: the surrounding trace/execute stage and predictor.
interface branch_resolver_if;
  logic br_valid;
  logic br_taken;
  logic br_ready;
  logic request;
  logic prediction;
  logic result;
  logic taken;
  logic mispredict;

  modport slave (
    input  br_valid, br_taken, prediction,
    output br_ready, request, result, taken, mispredict
  );

  modport master (
    output br_valid, br_taken, prediction,
    input  br_ready, request, result, taken, mispredict
  );
endinterface

// File: rtl/br_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module br_sat_counter
  import br_resolver_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_nxt;

  always_comb begin
    count_nxt = WIDTH'(sat_inc(64'(count), WIDTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: accepts resolved branches, samples the predictor, trains it and
// counts hits/misses. Optional outcome history register enabled by BR_RESOLVER_HIST_EN.
module branch_resolver
  import br_resolver_pkg::*;
#(
`ifdef BR_RESOLVER_HIST_EN
  parameter int unsigned HIST_LEN    = 8,
`endif
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned RESOLVE_DLY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolver_if.slave     bus,
  input  logic                 cnt_clr,
`ifdef BR_RESOLVER_HIST_EN
  output logic [HIST_LEN-1:0]  br_hist,
`endif
  output logic [CNT_W-1:0]     br_total_cnt,
  output logic [CNT_W-1:0]     br_miss_cnt
);

  localparam logic [3:0] DLY_LOAD = 4'((RESOLVE_DLY == 0) ? 0 : RESOLVE_DLY - 1);

  state_t     state;
  logic       outcome_q;
  logic       pred_q;
  logic [3:0] dly_cnt;
  logic       inc_total;
  logic       inc_miss;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.br_ready   <= 1'b0;
      bus.request    <= 1'b0;
      bus.result     <= 1'b0;
      bus.taken      <= NOT_TAKEN;
      bus.mispredict <= 1'b0;
      outcome_q      <= NOT_TAKEN;
      pred_q         <= NOT_TAKEN;
      dly_cnt        <= '0;
    end else begin
      bus.request    <= 1'b0;
      bus.result     <= 1'b0;
      bus.taken      <= NOT_TAKEN;
      bus.mispredict <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.br_valid && bus.br_ready) begin
            outcome_q    <= bus.br_taken;
            bus.br_ready <= 1'b0;
            bus.request  <= 1'b1;
            state        <= REQ;
          end else begin
            bus.br_ready <= 1'b1;
          end
        end
        REQ: state <= WAIT;
        WAIT: begin
          pred_q <= bus.prediction;
          // With no extra delay the live prediction feeds the mispredict compare directly.
          if (RESOLVE_DLY == 0) begin
            bus.result     <= 1'b1;
            bus.taken      <= outcome_q;
            bus.mispredict <= (bus.prediction != outcome_q);
            state          <= RESOLVE;
          end else begin
            dly_cnt <= DLY_LOAD;
            state   <= DLY;
          end
        end
        DLY: begin
          if (dly_cnt == '0) begin
            bus.result     <= 1'b1;
            bus.taken      <= outcome_q;
            bus.mispredict <= (pred_q != outcome_q);
            state          <= RESOLVE;
          end else begin
            dly_cnt <= dly_cnt - 4'd1;
          end
        end
        RESOLVE: begin
          bus.br_ready <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    inc_total = (state == RESOLVE);
    inc_miss  = (state == RESOLVE) && bus.mispredict;
  end

  br_sat_counter #(.WIDTH(CNT_W)) u_total (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_total),
    .clr   (cnt_clr),
    .count (br_total_cnt)
  );

  br_sat_counter #(.WIDTH(CNT_W)) u_miss (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_miss),
    .clr   (cnt_clr),
    .count (br_miss_cnt)
  );

`ifdef BR_RESOLVER_HIST_EN
  logic [HIST_LEN-1:0] hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else if (state == RESOLVE) begin
      hist_q <= {hist_q[HIST_LEN-2:0], outcome_q};
    end
  end

  assign br_hist = hist_q;
`endif

endmodule
